// File: rtl/linebuf_pingpong_ctrl.sv
// Ping-pong controller for the two-bank line buffer between the pooling writer and channel reader.
// Optional saturating error counters are built when LBUF_ERR_STATS_EN is defined.
module linebuf_pingpong_ctrl #(
  parameter int unsigned WIDTH_D = 27,
  parameter int unsigned THREAD  = 2,
  parameter int unsigned WIDTH_A = 10,
  parameter int unsigned DEPTH   = 896
) (
  input  logic                       i_sclk,
  input  logic                       i_rst,
  input  logic                       i_vsync,
  input  logic                       i_wrvld,
  input  logic [WIDTH_A-1:0]         i_wrcnt,
  input  logic [WIDTH_D*THREAD-1:0]  i_wrdat,
  input  logic                       i_wrend,
  input  logic                       i_rdreq,
  input  logic [WIDTH_A-1:0]         i_rdcnt,
  input  logic                       i_rdend,
  output logic                       o_rdrdy,
  output logic [1:0]                 o_level,
  output logic                       o_rdvld,
  output logic [WIDTH_D*THREAD-1:0]  o_rddat,
  output logic                       o_ovf,
  output logic                       o_udf,
  output logic                       o_ram_we,
  output logic [WIDTH_A:0]           o_ram_waddr,
  output logic [WIDTH_D*THREAD-1:0]  o_ram_wdat,
  output logic                       o_ram_re,
  output logic [WIDTH_A:0]           o_ram_raddr,
  input  logic [WIDTH_D*THREAD-1:0]  i_ram_rdat
`ifdef LBUF_ERR_STATS_EN
  ,
  output logic [15:0]                o_ovf_cnt,
  output logic [15:0]                o_udf_cnt
`endif
);

  localparam int unsigned    WordW    = WIDTH_D * THREAD;
  localparam logic [WIDTH_A:0] DepthLim = DEPTH[WIDTH_A:0];

  typedef enum logic [1:0] {StIdle, StFill, StStream, StFull} state_e;

  state_e             state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic               rdrdy_q;
  logic [1:0]         level_q, level_d;
  logic               ovf_q, udf_q;
  logic               ram_we_q;
  logic [WIDTH_A:0]   ram_waddr_q;
  logic [WordW-1:0]   ram_wdat_q;
  logic               ram_re_q;
  logic [WIDTH_A:0]   ram_raddr_q;
  logic               rd_pend_q;
  logic               rdvld_q;
  logic [WordW-1:0]   rddat_q;

  logic wr_ok, wr_rej, wend_ok, wend_rej;
  logic rd_ok, rd_rej, rend_ok, rend_rej;

  always_comb begin
    wr_ok    = i_wrvld && !full_q[wr_bank_q] && ({1'b0, i_wrcnt} < DepthLim);
    wr_rej   = i_wrvld && !wr_ok;
    wend_ok  = i_wrend && !full_q[wr_bank_q];
    wend_rej = i_wrend && full_q[wr_bank_q];
    rd_ok    = i_rdreq && full_q[rd_bank_q] && ({1'b0, i_rdcnt} < DepthLim);
    rd_rej   = i_rdreq && !rd_ok;
    rend_ok  = i_rdend && full_q[rd_bank_q];
    rend_rej = i_rdend && !full_q[rd_bank_q];
  end

  // Writer and reader never hold the same bank when both ends are accepted, so the updates commute.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wend_ok) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rend_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    level_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wend_ok)    state_d = StStream;
        else if (wr_ok) state_d = StFill;
      end
      StFill: begin
        if (wend_ok) state_d = StStream;
      end
      StStream: begin
        if (wend_ok && !rend_ok)      state_d = StFull;
        else if (rend_ok && !wend_ok) state_d = StFill;
      end
      StFull: begin
        if (rend_ok) state_d = StStream;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rdrdy_q     <= 1'b0;
      level_q     <= 2'd0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdat_q  <= '0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
      rd_pend_q   <= 1'b0;
      rdvld_q     <= 1'b0;
      rddat_q     <= '0;
    end else if (i_vsync) begin
      // Frame-start clear keeps the sticky error flags for debug.
      state_q     <= StIdle;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rdrdy_q     <= 1'b0;
      level_q     <= 2'd0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdat_q  <= '0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
      rd_pend_q   <= 1'b0;
      rdvld_q     <= 1'b0;
      rddat_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      rdrdy_q   <= full_d[rd_bank_d];
      level_q   <= level_d;
      ovf_q     <= ovf_q | wr_rej | wend_rej;
      udf_q     <= udf_q | rd_rej | rend_rej;
      ram_we_q  <= wr_ok;
      if (wr_ok) begin
        ram_waddr_q <= {wr_bank_q, i_wrcnt};
        ram_wdat_q  <= i_wrdat;
      end
      ram_re_q  <= rd_ok;
      if (rd_ok) ram_raddr_q <= {rd_bank_q, i_rdcnt};
      // RAM returns data one cycle after the strobe; register it once more for timing.
      rd_pend_q <= ram_re_q;
      rdvld_q   <= rd_pend_q;
      if (rd_pend_q) rddat_q <= i_ram_rdat;
    end
  end

  assign o_rdrdy     = rdrdy_q;
  assign o_level     = level_q;
  assign o_rdvld     = rdvld_q;
  assign o_rddat     = rddat_q;
  assign o_ovf       = ovf_q;
  assign o_udf       = udf_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_waddr = ram_waddr_q;
  assign o_ram_wdat  = ram_wdat_q;
  assign o_ram_re    = ram_re_q;
  assign o_ram_raddr = ram_raddr_q;

`ifdef LBUF_ERR_STATS_EN
  logic [15:0] ovf_cnt_q, udf_cnt_q;
  logic [1:0]  ovf_evt, udf_evt;

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    ovf_evt = {1'b0, wr_rej} + {1'b0, wend_rej};
    udf_evt = {1'b0, rd_rej} + {1'b0, rend_rej};
  end

  // Only a hard reset clears the counters; frame starts do not.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      ovf_cnt_q <= 16'd0;
      udf_cnt_q <= 16'd0;
    end else if (!i_vsync) begin
      ovf_cnt_q <= sat_add(ovf_cnt_q, ovf_evt);
      udf_cnt_q <= sat_add(udf_cnt_q, udf_evt);
    end
  end

  assign o_ovf_cnt = ovf_cnt_q;
  assign o_udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_linebuf_pingpong_ctrl.sv
// Randomized self-checking bench for linebuf_pingpong_ctrl against a bank/queue reference model.
module tb_linebuf_pingpong_ctrl;
  localparam int unsigned WD = 27, TH = 2, WA = 10, DEPTH = 896;
  localparam int unsigned W = WD * TH;
  localparam int unsigned ObsW = 1 + 2 + 1 + 1 + 1 + (WA + 1) + W + 1 + (WA + 1) + 1 + W;

  logic sclk = 1'b0, rst = 1'b0, vsync = 1'b0;
  logic wrvld = 1'b0, wrend = 1'b0, rdreq = 1'b0, rdend = 1'b0;
  logic [WA-1:0] wrcnt = '0, rdcnt = '0;
  logic [W-1:0] wrdat = '0, ram_rdat = '0;
  logic rdrdy, rdvld, ovf, udf, ram_we, ram_re;
  logic [1:0] level;
  logic [W-1:0] rddat, ram_wdat;
  logic [WA:0] ram_waddr, ram_raddr;
`ifdef LBUF_ERR_STATS_EN
  logic [15:0] ovf_cnt, udf_cnt;
`endif

  linebuf_pingpong_ctrl #(.WIDTH_D(WD), .THREAD(TH), .WIDTH_A(WA), .DEPTH(DEPTH)) dut (
    .i_sclk(sclk), .i_rst(rst), .i_vsync(vsync), .i_wrvld(wrvld), .i_wrcnt(wrcnt),
    .i_wrdat(wrdat), .i_wrend(wrend), .i_rdreq(rdreq), .i_rdcnt(rdcnt), .i_rdend(rdend),
    .o_rdrdy(rdrdy), .o_level(level), .o_rdvld(rdvld), .o_rddat(rddat), .o_ovf(ovf),
    .o_udf(udf), .o_ram_we(ram_we), .o_ram_waddr(ram_waddr), .o_ram_wdat(ram_wdat),
    .o_ram_re(ram_re), .o_ram_raddr(ram_raddr), .i_ram_rdat(ram_rdat)
`ifdef LBUF_ERR_STATS_EN
    , .o_ovf_cnt(ovf_cnt), .o_udf_cnt(udf_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  // Behavioural RAM: synchronous write, registered read.
  logic [W-1:0] mem [2**(WA+1)];
  always @(posedge sclk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdat;
    if (ram_re) ram_rdat <= mem[ram_raddr];
  end

  // Reference model: bank occupancy, pointers, sticky flags and a queue of pending read results.
  typedef struct {int unsigned due; logic [W-1:0] d;} rd_t;
  rd_t rq[$];
  logic [W-1:0] shadow [2**(WA+1)];
  logic [1:0] m_full;
  logic m_wb, m_rb, m_ovf, m_udf;
  logic e_we, e_re, e_rdvld;
  logic [WA:0] e_waddr, e_raddr;
  logic [W-1:0] e_wdat, e_rddat;
  int unsigned cyc = 0;
  int n_cmp = 0, n_err = 0;

  function automatic logic [ObsW-1:0] observe();
    return {rdrdy, level, ovf, udf, ram_we, ram_we ? ram_waddr : '0, ram_we ? ram_wdat : '0,
            ram_re, ram_re ? ram_raddr : '0, rdvld, rdvld ? rddat : '0};
  endfunction

  function automatic logic [ObsW-1:0] expect_obs();
    logic [1:0] lvl;
    lvl = 2'(m_full[0]) + 2'(m_full[1]);
    return {m_full[m_rb], lvl, m_ovf, m_udf, e_we, e_we ? e_waddr : '0, e_we ? e_wdat : '0,
            e_re, e_re ? e_raddr : '0, e_rdvld, e_rdvld ? e_rddat : '0};
  endfunction

  task automatic model_clear(input logic hard);
    m_full = 2'b00; m_wb = 1'b0; m_rb = 1'b0;
    e_we = 1'b0; e_re = 1'b0; e_rdvld = 1'b0;
    e_waddr = '0; e_raddr = '0; e_wdat = '0; e_rddat = '0;
    rq.delete();
    if (hard) begin m_ovf = 1'b0; m_udf = 1'b0; end
  endtask

  task automatic model_step();
    logic wr_acc, wend_acc, rd_acc, rend_acc;
    if (rst)   begin model_clear(1'b1); return; end
    if (vsync) begin model_clear(1'b0); return; end
    e_rdvld = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rdvld = 1'b1; e_rddat = rq[0].d; rq.delete(0);
    end
    wr_acc   = wrvld && !m_full[m_wb] && (int'(wrcnt) < DEPTH);
    wend_acc = wrend && !m_full[m_wb];
    rd_acc   = rdreq && m_full[m_rb] && (int'(rdcnt) < DEPTH);
    rend_acc = rdend && m_full[m_rb];
    if ((wrvld && !wr_acc) || (wrend && !wend_acc)) m_ovf = 1'b1;
    if ((rdreq && !rd_acc) || (rdend && !rend_acc)) m_udf = 1'b1;
    e_we = wr_acc;
    if (wr_acc) begin
      e_waddr = {m_wb, wrcnt}; e_wdat = wrdat; shadow[{m_wb, wrcnt}] = wrdat;
    end
    e_re = rd_acc;
    if (rd_acc) begin
      e_raddr = {m_rb, rdcnt};
      rq.push_back('{due: cyc + 2, d: shadow[{m_rb, rdcnt}]});
    end
    if (wend_acc) begin m_full[m_wb] = 1'b1; m_wb = ~m_wb; end
    if (rend_acc) begin m_full[m_rb] = 1'b0; m_rb = ~m_rb; end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
    cyc++;
    model_step();
  endtask

  task automatic idle_in();
    vsync = 0; wrvld = 0; wrend = 0; rdreq = 0; rdend = 0;
  endtask

  task automatic rand_dat();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    wrdat = r[W-1:0];
  endtask

  function automatic logic [WA-1:0] rand_addr();
    if ($urandom_range(0, 19) == 0) return WA'(DEPTH + $urandom_range(0, 127));
    return WA'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic hard_reset();
    idle_in(); rst = 1; tick(); rst = 0;
  endtask

  // Writes n words at addresses 0..n-1 of the current write bank, ending the block on the last.
  task automatic write_block(input int n);
    for (int a = 0; a < n; a++) begin
      wrvld = 1; wrcnt = WA'(a); rand_dat(); wrend = (a == n - 1);
      tick();
    end
    idle_in();
  endtask

  task automatic test_reset();
    idle_in(); rst = 1; #1;
    n_cmp++;
    if (observe() !== '0) begin
      n_err++; $display("FAIL reset_async got=%h exp=0", observe());
    end
    tick(); rst = 0; tick();
    n_cmp++;
    if (observe() !== expect_obs()) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", observe(), expect_obs());
    end
  endtask

  task automatic test_fill_read();
    hard_reset();
    for (int a = 0; a < DEPTH; a++) begin
      wrvld = 1; wrcnt = WA'(a); rand_dat(); wrend = (a == DEPTH - 1);
      tick();
      n_cmp++;
      if (observe() !== expect_obs()) begin
        n_err++; $display("FAIL fill cyc=%0d got=%h exp=%h", cyc, observe(), expect_obs());
      end
    end
    idle_in();
    n_cmp++;
    if (rdrdy !== 1'b1 || level !== 2'd1) begin
      n_err++; $display("FAIL fill_done rdrdy=%b level=%0d exp rdrdy=1 level=1", rdrdy, level);
    end
    for (int i = 0; i < DEPTH + 4; i++) begin
      idle_in();
      if (i < DEPTH && $urandom_range(0, 3) != 0) begin
        rdreq = 1; rdcnt = WA'($urandom_range(0, DEPTH - 1));
      end
      rdend = (i == DEPTH - 1);
      tick();
      n_cmp++;
      if (observe() !== expect_obs()) begin
        n_err++; $display("FAIL read cyc=%0d got=%h exp=%h", cyc, observe(), expect_obs());
      end
    end
    n_cmp++;
    if (rdrdy !== 1'b0 || level !== 2'd0 || udf !== 1'b0) begin
      n_err++; $display("FAIL read_done rdrdy=%b level=%0d udf=%b exp 0 0 0", rdrdy, level, udf);
    end
  endtask

  task automatic test_addr_range();
    hard_reset();
    wrvld = 1; wrcnt = WA'(DEPTH); rand_dat(); tick();
    wrcnt = '1; tick(); idle_in(); tick();
    n_cmp++;
    if (observe() !== expect_obs() || ovf !== 1'b1) begin
      n_err++; $display("FAIL wr_range got=%h exp=%h", observe(), expect_obs());
    end
    hard_reset(); write_block(8);
    rdreq = 1; rdcnt = WA'(DEPTH); tick(); idle_in();
    n_cmp++;
    if (ram_re !== 1'b0 || udf !== 1'b1) begin
      n_err++; $display("FAIL rd_range ram_re=%b udf=%b exp 0 1", ram_re, udf);
    end
  endtask

  task automatic test_overflow();
    hard_reset(); write_block(4); write_block(4);
    n_cmp++;
    if (level !== 2'd2 || ovf !== 1'b0) begin
      n_err++; $display("FAIL two_full level=%0d ovf=%b exp 2 0", level, ovf);
    end
    wrvld = 1; wrcnt = 10'd5; rand_dat(); tick(); idle_in();
    n_cmp++;
    if (ram_we !== 1'b0 || ovf !== 1'b1 || level !== 2'd2) begin
      n_err++; $display("FAIL ovf_write we=%b ovf=%b level=%0d exp 0 1 2", ram_we, ovf, level);
    end
    wrend = 1; tick(); idle_in(); tick();
    n_cmp++;
    if (observe() !== expect_obs()) begin
      n_err++; $display("FAIL ovf_wrend got=%h exp=%h", observe(), expect_obs());
    end
  endtask

  task automatic test_underflow();
    hard_reset();
    rdreq = 1; rdcnt = 10'd3; rdend = 1; tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ram_re !== 1'b0 || rdvld !== 1'b0 || udf !== 1'b1 || level !== 2'd0) begin
        n_err++;
        $display("FAIL udf i=%0d re=%b vld=%b udf=%b lvl=%0d exp 0 0 1 0", i, ram_re, rdvld, udf,
                 level);
      end
    end
  endtask

  task automatic test_simul_ends();
    hard_reset(); write_block(8);
    for (int a = 0; a < 4; a++) begin
      wrvld = 1; wrcnt = WA'(a); rand_dat(); tick();
    end
    idle_in(); wrend = 1; rdend = 1; tick(); idle_in();
    n_cmp++;
    if (level !== 2'd1 || rdrdy !== 1'b1 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_err++;
      $display("FAIL simul_ends level=%0d rdrdy=%b ovf=%b udf=%b exp 1 1 0 0", level, rdrdy, ovf,
               udf);
    end
    wrvld = 1; wrcnt = 10'd7; rand_dat(); rdreq = 1; rdcnt = 10'd2; tick(); idle_in();
    n_cmp++;
    if (ram_we !== 1'b1 || ram_waddr !== 11'h007 || ram_re !== 1'b1 || ram_raddr !== 11'h402) begin
      n_err++;
      $display("FAIL simul_banks we=%b wa=%h re=%b ra=%h exp 1 007 1 402", ram_we, ram_waddr,
               ram_re, ram_raddr);
    end
  endtask

  task automatic test_vsync();
    hard_reset(); write_block(16);
    wrvld = 1; wrcnt = '1; tick(); idle_in();
    for (int i = 0; i < 6; i++) begin
      rdreq = 1; rdcnt = WA'(i); vsync = (i == 3);
      tick();
      n_cmp++;
      if (observe() !== expect_obs()) begin
        n_err++; $display("FAIL vsync_rd i=%0d got=%h exp=%h", i, observe(), expect_obs());
      end
    end
    idle_in(); vsync = 1; tick(); idle_in(); tick();
    n_cmp++;
    if (level !== 2'd0 || rdrdy !== 1'b0 || ovf !== 1'b1 || rdvld !== 1'b0) begin
      n_err++;
      $display("FAIL vsync_clr level=%0d rdrdy=%b ovf=%b vld=%b exp 0 0 1 0", level, rdrdy, ovf,
               rdvld);
    end
    rst = 1; tick(); rst = 0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL rst_ovf got=%b exp=0", ovf);
    end
  endtask

  task automatic test_reset_midburst();
    hard_reset(); write_block(32);
    for (int i = 0; i < 5; i++) begin
      rdreq = 1; rdcnt = WA'(i); tick();
    end
    rst = 1; #1;
    n_cmp++;
    if (observe() !== '0) begin
      n_err++; $display("FAIL rst_midburst got=%h exp=0", observe());
    end
    idle_in(); tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (observe() !== expect_obs() || rdvld !== 1'b0) begin
        n_err++; $display("FAIL rst_drain i=%0d got=%h exp=%h", i, observe(), expect_obs());
      end
    end
  endtask

  task automatic test_random();
    hard_reset();
    for (int i = 0; i < 4000; i++) begin
      wrvld = ($urandom_range(0, 9) < 7); wrcnt = rand_addr(); rand_dat();
      wrend = ($urandom_range(0, 49) == 0);
      rdreq = ($urandom_range(0, 9) < 6); rdcnt = rand_addr();
      rdend = ($urandom_range(0, 49) == 0);
      vsync = ($urandom_range(0, 499) == 0);
      tick();
      n_cmp++;
      if (observe() !== expect_obs()) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observe(), expect_obs());
      end
    end
    idle_in();
  endtask

  initial begin
    for (int i = 0; i < 2**(WA+1); i++) begin
      mem[i] = '0; shadow[i] = '0;
    end
    model_clear(1'b1);
    test_reset();
    test_fill_read();
    test_addr_range();
    test_overflow();
    test_underflow();
    test_simul_ends();
    test_vsync();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/linebuf_pingpong_ctrl.md
Name: linebuf_pingpong_ctrl

Overview:
- Controller and arbiter for the two-bank line-buffer RAM that sits between the pooling write side and the channel-serial read side of the L1 reshape/max-pool stage.
- Steers writes into one bank while the reader drains the other.
- Tracks bank full/empty state and issues the RAM read/write strobes and addresses.
- Flags overflow/underflow so the upstream producer and downstream consumer can be throttled or debugged.

Parameters:
- WIDTH_D, 27, bits per lane
- THREAD, 2, lanes packed per RAM word
- WIDTH_A, 10, address width inside one bank
- DEPTH, 896, words per bank (SIZE/STEP*CHANNEL/STEP); must be <= 2**WIDTH_A

Ports:
- i_sclk  in  1  clock, all logic on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_vsync  in  1  frame start; synchronous soft clear, same effect as reset except sticky flags
- i_wrvld  in  1  write strobe from the pooling side
- i_wrcnt  in  WIDTH_A  write address within the current row block
- i_wrdat  in  WIDTH_D*THREAD  write data
- i_wrend  in  1  pulse marking the block's last write; may coincide with i_wrvld
- i_rdreq  in  1  read strobe from the consumer
- i_rdcnt  in  WIDTH_A  read address within the readable bank
- i_rdend  in  1  pulse: consumer has finished the readable bank
- o_rdrdy  out  1  a full bank is available to read
- o_level  out  2  number of full banks (0..2)
- o_rdvld  out  1  read data valid
- o_rddat  out  WIDTH_D*THREAD  read data
- o_ovf  out  1  sticky: write dropped
- o_udf  out  1  sticky: read or rdend dropped
- o_ram_we  out  1  RAM write enable
- o_ram_waddr  out  WIDTH_A+1  {bank, address}
- o_ram_wdat  out  WIDTH_D*THREAD  RAM write data
- o_ram_re  out  1  RAM read enable
- o_ram_raddr  out  WIDTH_A+1  {bank, address}
- i_ram_rdat  in  WIDTH_D*THREAD  RAM read data, one cycle after o_ram_re

Behaviour:
- Reset: every output is 0; wr_bank=0, rd_bank=0, full=2'b00, state=IDLE.
- i_vsync: same clear as reset, except o_ovf and o_udf are held.

State machine:
- IDLE
  - First accepted write -> FILL.
- FILL (no bank full)
  - Accepted i_wrend -> STREAM.
- STREAM (one bank full)
  - Second bank completes -> FULL.
  - Reader i_rdend on the last full bank -> FILL.
- FULL (both banks full)
  - Accepted i_rdend -> STREAM.
- Simultaneous accepted wrend and rdend in STREAM: level is unchanged; state stays STREAM.

Write path:
- A write is accepted when i_wrvld=1, full[wr_bank]=0 and i_wrcnt<DEPTH.
- Accepted write: next cycle o_ram_we=1, o_ram_waddr={wr_bank,i_wrcnt}, o_ram_wdat=i_wrdat. Latency is 1 cycle.
- Rejected write: no RAM strobe; o_ovf is set.
- Accepted i_wrend (full[wr_bank]=0): full[wr_bank]<=1 and wr_bank toggles.
  - A write in the same cycle as i_wrend lands in the old bank.
- i_wrend while full[wr_bank]=1: ignored; o_ovf is set.

Read path:
- o_rdrdy = full[rd_bank], registered.
- A read is accepted when i_rdreq=1, full[rd_bank]=1 and i_rdcnt<DEPTH.
- Accepted read pipeline:
  - Next cycle: o_ram_re=1, o_ram_raddr={rd_bank,i_rdcnt}.
  - Following cycle: RAM returns i_ram_rdat.
  - One cycle after that: o_rdvld=1, o_rddat=i_ram_rdat.
  - Total latency from i_rdreq to o_rdvld is 3 cycles.
- Rejected read: no strobe, no o_rdvld; o_udf is set.
- Accepted i_rdend (full[rd_bank]=1): full[rd_bank]<=0 and rd_bank toggles.
  - Reads already in the pipeline still complete.
- i_rdend with full[rd_bank]=0: ignored; o_udf is set.

Other rules:
- o_level = full[0]+full[1], registered, updated the same cycle as full.
- Bank pointers are 1 bit and wrap 1->0.
- An address equal to DEPTH or above is never forwarded to the RAM.
- Reset asserted mid-burst: all outputs are cleared immediately; in-flight o_rdvld is dropped.

Optional Feature:
- Macro: LBUF_ERR_STATS_EN.
- Defined:
  - Adds outputs o_ovf_cnt[15:0] and o_udf_cnt[15:0].
  - Each counts rejected events, saturates at 16'hFFFF, and is cleared only by i_rst.
- Undefined: the counter ports and logic are absent; only the sticky flags remain.

Test Plan:
- Reset, then write addresses 0..895 into bank 0 plus i_wrend -> 896 RAM writes with waddr[WIDTH_A]=0; o_rdrdy=1 and o_level=1 the cycle after wrend.
- Read addresses 0..895 from the full bank -> o_rdvld asserted 3 cycles after each i_rdreq, o_rddat equals the written data; i_rdend -> o_level=0, o_rdrdy=0.
- Fill both banks, then attempt a third write -> no o_ram_we, o_ovf=1, o_level stays 2.
- i_rdreq and i_rdend with o_level=0 -> no o_ram_re, no o_rdvld, o_udf=1.
- In STREAM, pulse i_wrend on bank 1 and i_rdend on bank 0 in the same cycle -> o_level stays 1, wr_bank=0, rd_bank=1, no flags set.
- Assert i_vsync mid-read with o_ovf=1 -> full=0, o_rdrdy=0, o_ovf still 1; i_rst then clears o_ovf to 0.
